sr_bank_arbiter: RTL
====================

Name: sr_bank_arbiter

Overview:
- Shares one bank of WIDTH SR flip-flop cells between two requesters.
- Each request names a cell index and a mode: SR, D, JK or T. The controller converts the request's operands into S/R drive for that cell, applies it, and returns the new cell value.
- Arbitration between the two requesters is round-robin.
- The block sits beside the flip-flop conversion cells as their sequencing and sharing controller.

Parameters:
- WIDTH, 8, number of SR cells in the bank.
- IDXW, 3, width of the cell index; must satisfy 2**IDXW >= WIDTH.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- req_valid0, req_valid1  input  1 each  request valid, requester 0 / 1.
- req_ready0, req_ready1  output  1 each  request accepted this cycle, requester 0 / 1.
- req_mode0, req_mode1  input  2 each  00=SR, 01=D, 10=JK, 11=T.
- req_idx0, req_idx1  input  IDXW each  target cell index.
- req_a0, req_a1  input  1 each  operand A (S / D / J / T).
- req_b0, req_b1  input  1 each  operand B (R / unused / K / unused).
- resp_valid0, resp_valid1  output  1 each  one-cycle response strobe to requester 0 / 1.
- resp_q  output  1  updated cell value; valid while a resp_valid strobe is high.
- resp_err  output  1  error flag; qualified by resp_valid.
- q_bank  output  WIDTH  current contents of all cells.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - q_bank=0, state=IDLE, last_grant=1 (so requester 0 wins the first tie).
  - All resp_valid=0, resp_q=0, resp_err=0, busy=0.
- Reset asserted mid-operation aborts the command: no response is issued and the bank clears.
- State machine: IDLE -> APPLY -> RESP -> IDLE.
- IDLE:
  - Grant is combinational. If only one requester is valid, it is granted. If both are valid, grant the requester other than last_grant.
  - req_readyN = (state==IDLE) && granted==N. Ready may depend on valid.
  - On valid&&ready, latch mode, idx, a, b and the grant id; next state is APPLY.
- APPLY: compute S/R from the latched command and the current cell value q=q_bank[idx].
  - SR: S=a, R=b.
  - D: S=a, R=~a.
  - JK: S=a&~q, R=b&q.
  - T: S=a&~q, R=a&q.
  - Cell update at the APPLY->RESP edge:
    - S&~R: cell=1.
    - R&~S: cell=0.
    - S=R=0: cell holds.
    - S=R=1 (SR mode only): cell holds, resp_err=1.
  - idx >= WIDTH: no cell changes, resp_err=1, resp_q=0.
- RESP:
  - resp_valid of the granted requester is high for exactly one cycle.
  - resp_q = new cell value; resp_err as computed in APPLY.
  - last_grant <= grant id; next state is IDLE.
- Latency: handshake at edge E0; bank updated at E0+1; response visible in the cycle after E0+1; IDLE again at E0+2.
- Throughput: one command per 3 cycles.
- Responses have no back-pressure.
- Requests not accepted must hold their fields stable until ready; the block does not queue requests.
- The non-granted requester waits with ready low. The round-robin pointer bounds its wait to one command.
- q_bank reflects only committed updates and changes only on the APPLY->RESP edge.

Test Plan:
- Reset check: assert rst for 2 cycles -> q_bank=0, busy=0, both ready low with no valid. Then req_valid0=1 -> req_ready0=1 combinationally.
- D mode: requester 0, idx=3, a=1 -> q_bank=8'h08 after E0+1. Next cycle resp_valid0=1, resp_q=1, resp_err=0. Repeat with a=0 -> q_bank=8'h00.
- JK/T toggle: T mode, idx=5, a=1, issued twice -> q_bank 8'h20 then 8'h00. JK with a=b=1 on idx=5 -> 8'h20. JK with a=0, b=1 -> 8'h00.
- SR illegal: preload idx=1 to 1, then SR a=b=1 -> cell stays 1, resp_err=1, resp_q=1.
- Arbitration: both requesters valid continuously, four commands -> grant order 0,1,0,1. resp_valid goes only to the granted requester, and each response appears 2 edges after its handshake.
- Reset mid-op: assert rst during APPLY of a D write of 1 to idx=0 -> no resp_valid, q_bank=0. After release, the first tie is granted to requester 0.

Source files
------------

// File: rtl/sr_bank_arbiter.sv
// Round-robin controller sharing a bank of SR cells between two requesters.
// Each command is converted from SR/D/JK/T form into S/R drive, applied, then answered.
module sr_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid0,
  input  logic             req_valid1,
  output logic             req_ready0,
  output logic             req_ready1,
  input  logic [1:0]       req_mode0,
  input  logic [1:0]       req_mode1,
  input  logic [IDXW-1:0]  req_idx0,
  input  logic [IDXW-1:0]  req_idx1,
  input  logic             req_a0,
  input  logic             req_a1,
  input  logic             req_b0,
  input  logic             req_b1,
  output logic             resp_valid0,
  output logic             resp_valid1,
  output logic             resp_q,
  output logic             resp_err,
  output logic [WIDTH-1:0] q_bank,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] APPLY = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_D  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  logic [1:0]      state;
  logic [1:0]      cmd_mode;
  logic [IDXW-1:0] cmd_idx;
  logic            cmd_a;
  logic            cmd_b;
  logic            cmd_id;
  logic            last_grant;

  logic            grant;
  logic            handshake;
  logic            idx_ok;
  logic            cur_q;
  logic            s;
  logic            r;
  logic            new_q;
  logic            apply_err;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    if (req_valid0 && req_valid1) grant = ~last_grant;
    else                          grant = req_valid1;
  end

  assign req_ready0 = (state == IDLE) && req_valid0 && !grant;
  assign req_ready1 = (state == IDLE) && req_valid1 &&  grant;
  assign handshake  = req_ready0 || req_ready1;

  assign idx_ok = (int'(cmd_idx) < WIDTH);
  assign cur_q  = idx_ok ? q_bank[cmd_idx] : 1'b0;

  // NOTE: s and r get defaults before the case so no path leaves them unassigned (no latch).
  always_comb begin
    s = 1'b0;
    r = 1'b0;
    case (cmd_mode)
      MODE_SR: begin s = cmd_a;          r = cmd_b;         end
      MODE_D:  begin s = cmd_a;          r = ~cmd_a;        end
      MODE_JK: begin s = cmd_a & ~cur_q; r = cmd_b & cur_q; end
      MODE_T:  begin s = cmd_a & ~cur_q; r = cmd_a & cur_q; end
      default: begin s = 1'b0;           r = 1'b0;          end
    endcase
  end

  // S=R=1 can only arise from SR mode; the cell holds and the command is flagged.
  assign new_q     = (s & ~r) ? 1'b1 : ((r & ~s) ? 1'b0 : cur_q);
  assign apply_err = !idx_ok || (s & r);

  // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cmd_mode   <= MODE_SR;
      cmd_idx    <= '0;
      cmd_a      <= 1'b0;
      cmd_b      <= 1'b0;
      cmd_id     <= 1'b0;
      last_grant <= 1'b1;
      q_bank     <= '0;
      resp_q     <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            cmd_mode <= grant ? req_mode1 : req_mode0;
            cmd_idx  <= grant ? req_idx1  : req_idx0;
            cmd_a    <= grant ? req_a1    : req_a0;
            cmd_b    <= grant ? req_b1    : req_b0;
            cmd_id   <= grant;
            state    <= APPLY;
          end
        end
        APPLY: begin
          if (idx_ok) q_bank[cmd_idx] <= new_q;
          resp_q   <= idx_ok ? new_q : 1'b0;
          resp_err <= apply_err;
          state    <= RESP;
        end
        RESP: begin
          last_grant <= cmd_id;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign resp_valid0 = (state == RESP) && !cmd_id;
  assign resp_valid1 = (state == RESP) &&  cmd_id;
  assign busy        = (state != IDLE);

endmodule
